// File: rtl/vga_pixel_write_arbiter.sv
// ---------------------------------------------------------------------------
// vga_pixel_write_arbiter
//
// Shares one Avalon-MM write master into the VGA pixel buffer between
// NUM_REQ drawing engines. Each accepted request is one 8-bit pixel at (x, y).
// The pixel is turned into a byte address (row stride = 2**X_BITS bytes) and
// issued as a single write that is held through avm_waitrequest.
// Off-screen pixels are accepted and silently dropped (no bus cycle).
//
// Optional feature macro: PIX_ARB_STATS_EN
//   defined   -> write_count / drop_count are live counters
//   undefined -> both outputs are tied to zero and no counter flops exist
//
// Ports:
//   clk             in   system clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   arb_enable      in   0 blocks new grants (an in-flight write finishes)
//   req_valid       in   [NUM_REQ]          per-requester pixel request
//   req_ready       out  [NUM_REQ]          one-hot accept pulse
//   req_x           in   [NUM_REQ*X_BITS]   packed x coordinates
//   req_y           in   [NUM_REQ*Y_BITS]   packed y coordinates
//   req_color       in   [NUM_REQ*8]        packed pixel colours
//   avm_address     out  [32]  byte address of the write
//   avm_write       out        write strobe
//   avm_writedata   out  [8]   pixel colour
//   avm_waitrequest in         slave stall
//   busy            out        high while a write is in flight
//   write_count     out  [32]  completed writes (wraps)
//   drop_count      out  [16]  dropped off-screen pixels (saturates)
// ---------------------------------------------------------------------------
module vga_pixel_write_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          X_BITS   = 10,
  parameter int          Y_BITS   = 9,
  parameter int          H_RES    = 640,
  parameter int          V_RES    = 480,
  parameter logic [31:0] PIX_BASE = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        arb_enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*X_BITS-1:0]   req_x,
  input  logic [NUM_REQ*Y_BITS-1:0]   req_y,
  input  logic [NUM_REQ*8-1:0]        req_color,
  output logic [31:0]                 avm_address,
  output logic                        avm_write,
  output logic [7:0]                  avm_writedata,
  input  logic                        avm_waitrequest,
  output logic                        busy,
  output logic [31:0]                 write_count,
  output logic [15:0]                 drop_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [31:0]        addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic               wr_q, wr_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [PTR_W-1:0]   gnt_idx_s;
  logic               gnt_found_s;
  logic [X_BITS-1:0]  sel_x_s;
  logic [Y_BITS-1:0]  sel_y_s;
  logic [7:0]         sel_c_s;
  logic               in_range_s;
  logic [31:0]        pix_addr_s;
  logic [PTR_W-1:0]   rr_next_s;

  // Round-robin search starting at rr_ptr_q; only allowed while idle and enabled.
  always_comb begin : grant_comb
    logic [PTR_W-1:0] idx_v;
    grant_s     = '0;
    gnt_idx_s   = '0;
    gnt_found_s = 1'b0;
    idx_v       = '0;
    if (state_q == IDLE && arb_enable) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx_v = PTR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
        if (!gnt_found_s && req_valid[idx_v]) begin
          gnt_found_s = 1'b1;
          gnt_idx_s   = idx_v;
        end else begin
          gnt_found_s = gnt_found_s;
        end
      end
      if (gnt_found_s) begin
        grant_s[gnt_idx_s] = 1'b1;
      end else begin
        grant_s = '0;
      end
    end else begin
      grant_s = '0;
    end
  end

  assign req_ready = grant_s;

  // Mux the granted requester's pixel and derive its buffer address.
  always_comb begin
    sel_x_s    = req_x[int'(gnt_idx_s)*X_BITS +: X_BITS];
    sel_y_s    = req_y[int'(gnt_idx_s)*Y_BITS +: Y_BITS];
    sel_c_s    = req_color[int'(gnt_idx_s)*8 +: 8];
    in_range_s = (32'(sel_x_s) < 32'(H_RES)) && (32'(sel_y_s) < 32'(V_RES));
    // Row stride is 2**X_BITS bytes, so y simply shifts above x.
    pix_addr_s = PIX_BASE + (32'(sel_y_s) << X_BITS) + 32'(sel_x_s);
    rr_next_s  = (gnt_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_s + 1'b1;
  end

  // Next-state logic for the IDLE/ISSUE controller and its registered outputs.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    case (state_q)
      IDLE: begin
        if (gnt_found_s) begin
          rr_ptr_d = rr_next_s;
          if (in_range_s) begin
            state_d = ISSUE;
            addr_d  = pix_addr_s;
            data_d  = sel_c_s;
            wr_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (!avm_waitrequest) begin
          wr_d    = 1'b0;
          state_d = IDLE;
        end else begin
          wr_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        wr_d    = 1'b0;
      end
    endcase
  end

  // Controller state, round-robin pointer and bus output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      addr_q   <= 32'h0000_0000;
      data_q   <= 8'h00;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
    end
  end

  assign avm_address   = addr_q;
  assign avm_writedata = data_q;
  assign avm_write     = wr_q;
  assign busy          = (state_q != IDLE);

`ifdef PIX_ARB_STATS_EN
  logic [31:0] write_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        wr_done_s;
  logic        drop_s;

  assign wr_done_s = (state_q == ISSUE) && !avm_waitrequest;
  assign drop_s    = gnt_found_s && !in_range_s;

  // Completed-write counter (wraps) and dropped-pixel counter (saturates).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_cnt_q <= 32'h0000_0000;
      drop_cnt_q  <= 16'h0000;
    end else begin
      if (wr_done_s) begin
        write_cnt_q <= write_cnt_q + 32'd1;
      end else begin
        write_cnt_q <= write_cnt_q;
      end
      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end else begin
        drop_cnt_q <= drop_cnt_q;
      end
    end
  end

  assign write_count = write_cnt_q;
  assign drop_count  = drop_cnt_q;
`else
  assign write_count = 32'h0000_0000;
  assign drop_count  = 16'h0000;
`endif

endmodule

// File: doc/vga_pixel_write_arbiter.md
Name: vga_pixel_write_arbiter

Overview:
- Shares the single Avalon-MM write path into the VGA pixel buffer (SDRAM-backed, on the system side) between NUM_REQ drawing engines.
- Round-robin grant; each accepted request is one 8-bit pixel at (x, y).
- Converts (x, y) to a byte address and issues one Avalon write, holding it through waitrequest.
- Off-screen pixels are accepted and dropped without a bus cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- X_BITS, 10, x coordinate width; also the row stride as log2 bytes (stride 1024)
- Y_BITS, 9, y coordinate width
- H_RES, 640, visible width; x >= H_RES is dropped
- V_RES, 480, visible height; y >= V_RES is dropped
- PIX_BASE, 32'h0000_0000, byte base address of the pixel buffer

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- arb_enable  in  1  when 0, no new grants; an in-flight write still completes
- req_valid  in  NUM_REQ  per-requester pixel request
- req_ready  out  NUM_REQ  one-hot accept pulse; a request is consumed when valid&ready
- req_x  in  NUM_REQ*X_BITS  packed x coordinates, requester i at [i*X_BITS +: X_BITS]
- req_y  in  NUM_REQ*Y_BITS  packed y coordinates
- req_color  in  NUM_REQ*8  packed pixel colours
- avm_address  out  32  byte address of the write
- avm_write  out  1  write strobe
- avm_writedata  out  8  pixel colour
- avm_waitrequest  in  1  slave stall
- busy  out  1  1 whenever state != IDLE
- write_count  out  32  completed bus writes (see Optional Feature)
- drop_count  out  16  off-screen pixels dropped (see Optional Feature)

Behaviour:
- Reset values: req_ready=0, avm_write=0, avm_address=0, avm_writedata=0, busy=0, counters=0, rr_ptr=0, state=IDLE.
- FSM states: IDLE, ISSUE.
- IDLE:
  - If arb_enable && |req_valid, grant the first valid requester scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle.
  - Latch x, y and colour of requester g.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Range check on the latched coordinates:
  - In range (x < H_RES and y < V_RES): next state ISSUE; avm_address <= PIX_BASE + (y << X_BITS) + x, 32-bit unsigned, wrap ignored; avm_writedata <= colour; avm_write <= 1.
  - Out of range: stay in IDLE; drop_count increments and saturates at 16'hFFFF.
- ISSUE:
  - Hold avm_write, avm_address and avm_writedata stable while avm_waitrequest=1.
  - On the first cycle with avm_waitrequest=0 the write completes: avm_write <= 0, write_count++, return to IDLE.
  - req_ready=0 throughout.
- Latency: accept edge to avm_write=1 is 1 cycle. Peak throughput is 1 pixel per 2 cycles with zero wait states. A dropped pixel costs 1 cycle.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Only one req_ready bit is ever high. req_ready depends only on registered state, arb_enable and req_valid, never on avm_waitrequest.
- Requesters must hold valid and data until ready; dropping valid before ready is legal and simply withdraws the request.
- arb_enable falling during ISSUE: the current write finishes, then the block idles.
- Async reset mid-ISSUE: avm_write drops immediately. The write is abandoned; a slave-side partial transaction is accepted as system-level reset behaviour.
- Counters wrap: write_count wraps at 2^32; drop_count saturates.

Optional Feature:
- Macro: PIX_ARB_STATS_EN.
- Defined: write_count and drop_count are live registers as described above.
- Not defined: both outputs are tied to 0, no counter flops are built, and the rest of the behaviour is unchanged.

Test Plan:
- Req0 only, x=5, y=2, colour=8'hE0, waitrequest=0 → req_ready[0] pulses once; next cycle avm_write=1, avm_address=32'h0000_0805, avm_writedata=8'hE0, for exactly 1 cycle; write_count=1.
- All 4 requesters continuously valid, no stalls → grant order 0,1,2,3,0,1,... with a req_ready pulse every 2 cycles.
- avm_waitrequest held high 5 cycles during ISSUE → address and data stable for 6 cycles, req_ready stays 0, a single write completes.
- Req2 at x=640, y=0 → accepted, no avm_write; drop_count=1. Then x=639, y=479 → address=PIX_BASE+32'h0007_7E7F.
- arb_enable=0 with req1 valid → no req_ready. arb_enable falls during a stalled write → that write completes, then no further grants.
- reset_n asserted mid-ISSUE → avm_write=0 immediately; after release the state is IDLE and rr_ptr=0, so req0 wins an all-valid tie.
